// File: rtl/prof_pkg.sv
// Shared types and constants for the proof-buffer slot scheduler.
package prof_pkg;

  // state    | meaning
  // ST_FREE  | slot available for allocation
  // ST_FILL  | collecting sub-frames
  // ST_READY | all sub-frames stored, waiting for the proof engine
  // ST_RUN   | job handed to the proof engine
  typedef enum logic [1:0] {
    ST_FREE  = 2'd0,
    ST_FILL  = 2'd1,
    ST_READY = 2'd2,
    ST_RUN   = 2'd3
  } slot_st_e;

  localparam logic [1:0] ERR_CHKSUM   = 2'd0;
  localparam logic [1:0] ERR_BADSUB   = 2'd1;
  localparam logic [1:0] ERR_BADSTATE = 2'd2;
  localparam logic [1:0] ERR_TIMEOUT  = 2'd3;

  localparam logic [9:0] LEN_T1  = 10'd636;
  localparam logic [9:0] LEN_T0  = 10'd364;
  localparam logic [4:0] MASK_T1 = 5'h1f;
  localparam logic [4:0] MASK_T0 = 5'h07;

  function automatic logic [4:0] full_mask(input logic ty);
    return ty ? MASK_T1 : MASK_T0;
  endfunction

  function automatic logic [9:0] job_len(input logic ty);
    return ty ? LEN_T1 : LEN_T0;
  endfunction

endpackage

// File: rtl/prof_rr_arb.sv
// Round-robin pick among N request bits, starting the search at ptr_i.
module prof_rr_arb #(
  parameter int N = 8
) (
  input  logic [N-1:0] req_i,
  input  logic [2:0]   ptr_i,
  output logic [N-1:0] gnt_oh_o,
  output logic [2:0]   gnt_idx_o,
  output logic         any_o
);

  always_comb begin
    logic found;
    found     = 1'b0;
    gnt_oh_o  = '0;
    gnt_idx_o = '0;
    for (int k = 0; k < N; k++) begin
      for (int i = 0; i < N; i++) begin
        if (!found && req_i[i] && (i == ((int'(ptr_i) + k) % N))) begin
          found       = 1'b1;
          gnt_oh_o[i] = 1'b1;
          gnt_idx_o   = 3'(i);
        end
      end
    end
  end

  assign any_o = |req_i;

endmodule

// File: rtl/prof_slot_sched.sv
// Proof-buffer slot scheduler: allocates slots, tracks sub-frame fill, issues one job at a time.
// Optional fill watchdog enabled by defining PROF_SCHED_TMO_EN.
module prof_slot_sched
  import prof_pkg::*;
#(
  parameter int NSLOT   = 8,
  parameter int TMO_CYC = 65535
) (
  input  logic       clki,
  input  logic       rstni,
  input  logic       alloc_req_i,
  input  logic [7:0] alloc_task_i,
  input  logic       alloc_type_i,
  output logic       alloc_gnt_o,
  output logic [2:0] alloc_slot_o,
  input  logic       sub_done_i,
  input  logic [2:0] sub_slot_i,
  input  logic [2:0] sub_id_i,
  input  logic       sub_ok_i,
  output logic       job_valid_o,
  input  logic       job_ready_i,
  output logic [2:0] job_slot_o,
  output logic [7:0] job_task_o,
  output logic       job_type_o,
  output logic [9:0] job_len_o,
  input  logic       res_valid_i,
  input  logic [2:0] res_slot_i,
  output logic [3:0] free_cnt_o,
  output logic       err_valid_o,
  output logic [1:0] err_code_o,
  output logic [2:0] err_slot_o
);

  slot_st_e         st_q   [NSLOT];
  slot_st_e         st_d   [NSLOT];
  logic [7:0]       task_q [NSLOT];
  logic [7:0]       task_d [NSLOT];
  logic [4:0]       mask_q [NSLOT];
  logic [4:0]       mask_d [NSLOT];
  logic [NSLOT-1:0] type_q, type_d;
  logic [2:0]       rr_ptr_q, rr_ptr_d;
  logic             job_valid_q, job_valid_d;
  logic [2:0]       job_slot_q, job_slot_d;
  logic [7:0]       job_task_q, job_task_d;
  logic             job_type_q, job_type_d;
  logic [9:0]       job_len_q, job_len_d;
  logic             err_valid_q, err_valid_d;
  logic [1:0]       err_code_q, err_code_d;
  logic [2:0]       err_slot_q, err_slot_d;
  logic [3:0]       free_cnt_q, free_cnt_d;

  logic [NSLOT-1:0] free_vec, ready_vec, pick_oh;
  logic             run_any, pick_any;
  logic [2:0]       pick_idx, alloc_slot;

`ifdef PROF_SCHED_TMO_EN
  logic [15:0] tmo_q [NSLOT];
  logic [15:0] tmo_d [NSLOT];
`else
  logic [15:0] unused_tmo;
  assign unused_tmo = 16'(TMO_CYC);
`endif

  always_comb begin
    free_vec  = '0;
    ready_vec = '0;
    run_any   = 1'b0;
    for (int i = 0; i < NSLOT; i++) begin
      free_vec[i]  = (st_q[i] == ST_FREE);
      ready_vec[i] = (st_q[i] == ST_READY);
      if (st_q[i] == ST_RUN) run_any = 1'b1;
    end
  end

  always_comb begin
    alloc_slot = '0;
    for (int i = NSLOT - 1; i >= 0; i--) begin
      if (free_vec[i]) alloc_slot = 3'(i);
    end
  end

  assign alloc_gnt_o  = alloc_req_i & (|free_vec);
  assign alloc_slot_o = alloc_slot;

  prof_rr_arb #(.N(NSLOT)) u_arb (
    .req_i     (ready_vec),
    .ptr_i     (rr_ptr_q),
    .gnt_oh_o  (pick_oh),
    .gnt_idx_o (pick_idx),
    .any_o     (pick_any)
  );

  always_comb begin
    logic       sub_hit, res_hit, sub_err, res_err, tmo_err;
    logic [1:0] sub_code;
    logic [2:0] tmo_slot;
    logic [4:0] m;
    sub_hit  = 1'b0;
    res_hit  = 1'b0;
    sub_err  = 1'b0;
    res_err  = 1'b0;
    tmo_err  = 1'b0;
    sub_code = ERR_BADSTATE;
    tmo_slot = '0;
    m        = '0;
    type_d      = type_q;
    rr_ptr_d    = rr_ptr_q;
    job_valid_d = job_valid_q;
    job_slot_d  = job_slot_q;
    job_task_d  = job_task_q;
    job_type_d  = job_type_q;
    job_len_d   = job_len_q;
    err_valid_d = 1'b0;
    err_code_d  = '0;
    err_slot_d  = '0;
    free_cnt_d  = '0;

    for (int i = 0; i < NSLOT; i++) begin
      st_d[i]   = st_q[i];
      task_d[i] = task_q[i];
      mask_d[i] = mask_q[i];
`ifdef PROF_SCHED_TMO_EN
      tmo_d[i]  = tmo_q[i];
`endif
      if (alloc_gnt_o && alloc_slot == 3'(i)) begin
        st_d[i]   = ST_FILL;
        mask_d[i] = '0;
        task_d[i] = alloc_task_i;
        type_d[i] = alloc_type_i;
      end
      if (sub_done_i && sub_slot_i == 3'(i) && st_q[i] == ST_FILL) begin
        sub_hit = 1'b1;
        if (!sub_ok_i) begin
          st_d[i]  = ST_FREE;
          sub_err  = 1'b1;
          sub_code = ERR_CHKSUM;
        end else if (sub_id_i >= (type_q[i] ? 3'd5 : 3'd3)) begin
          st_d[i]  = ST_FREE;
          sub_err  = 1'b1;
          sub_code = ERR_BADSUB;
        end else begin
          m         = mask_q[i] | (5'd1 << sub_id_i);
          mask_d[i] = m;
          if (m == full_mask(type_q[i])) st_d[i] = ST_READY;
        end
      end
      if (res_valid_i && res_slot_i == 3'(i) && st_q[i] == ST_RUN) begin
        st_d[i] = ST_FREE;
        res_hit = 1'b1;
      end
      if (job_valid_q && job_ready_i && job_slot_q == 3'(i)) st_d[i] = ST_RUN;
`ifdef PROF_SCHED_TMO_EN
      // A sub-frame arriving this cycle restarts the watchdog and wins over expiry.
      if (alloc_gnt_o && alloc_slot == 3'(i)) begin
        tmo_d[i] = '0;
      end else if (st_q[i] == ST_FILL) begin
        if (sub_done_i && sub_slot_i == 3'(i)) begin
          tmo_d[i] = '0;
        end else if (tmo_q[i] == 16'(TMO_CYC)) begin
          st_d[i] = ST_FREE;
          if (!tmo_err) begin
            tmo_err  = 1'b1;
            tmo_slot = 3'(i);
          end
        end else begin
          tmo_d[i] = tmo_q[i] + 16'd1;
        end
      end
`endif
    end

    if (sub_done_i && !sub_hit) sub_err = 1'b1;
    res_err = res_valid_i && !res_hit;

    if (sub_err) begin
      err_valid_d = 1'b1;
      err_code_d  = sub_code;
      err_slot_d  = sub_slot_i;
    end else if (res_err) begin
      err_valid_d = 1'b1;
      err_code_d  = ERR_BADSTATE;
      err_slot_d  = res_slot_i;
    end else if (tmo_err) begin
      err_valid_d = 1'b1;
      err_code_d  = ERR_TIMEOUT;
      err_slot_d  = tmo_slot;
    end

    if (job_valid_q && job_ready_i) begin
      job_valid_d = 1'b0;
      rr_ptr_d    = 3'((int'(job_slot_q) + 1) % NSLOT);
    end else if (!job_valid_q && !run_any && pick_any) begin
      job_valid_d = 1'b1;
      job_slot_d  = pick_idx;
      for (int i = 0; i < NSLOT; i++) begin
        if (pick_oh[i]) begin
          job_task_d = task_q[i];
          job_type_d = type_q[i];
          job_len_d  = job_len(type_q[i]);
        end
      end
    end

    for (int i = 0; i < NSLOT; i++) begin
      if (st_d[i] == ST_FREE) free_cnt_d = free_cnt_d + 4'd1;
    end
  end

  always_ff @(posedge clki or negedge rstni) begin
    if (!rstni) begin
      for (int i = 0; i < NSLOT; i++) begin
        st_q[i]   <= ST_FREE;
        task_q[i] <= '0;
        mask_q[i] <= '0;
`ifdef PROF_SCHED_TMO_EN
        tmo_q[i]  <= '0;
`endif
      end
      type_q      <= '0;
      rr_ptr_q    <= '0;
      job_valid_q <= 1'b0;
      job_slot_q  <= '0;
      job_task_q  <= '0;
      job_type_q  <= 1'b0;
      job_len_q   <= '0;
      err_valid_q <= 1'b0;
      err_code_q  <= '0;
      err_slot_q  <= '0;
      free_cnt_q  <= 4'(NSLOT);
    end else begin
      for (int i = 0; i < NSLOT; i++) begin
        st_q[i]   <= st_d[i];
        task_q[i] <= task_d[i];
        mask_q[i] <= mask_d[i];
`ifdef PROF_SCHED_TMO_EN
        tmo_q[i]  <= tmo_d[i];
`endif
      end
      type_q      <= type_d;
      rr_ptr_q    <= rr_ptr_d;
      job_valid_q <= job_valid_d;
      job_slot_q  <= job_slot_d;
      job_task_q  <= job_task_d;
      job_type_q  <= job_type_d;
      job_len_q   <= job_len_d;
      err_valid_q <= err_valid_d;
      err_code_q  <= err_code_d;
      err_slot_q  <= err_slot_d;
      free_cnt_q  <= free_cnt_d;
    end
  end

  assign job_valid_o = job_valid_q;
  assign job_slot_o  = job_slot_q;
  assign job_task_o  = job_task_q;
  assign job_type_o  = job_type_q;
  assign job_len_o   = job_len_q;
  assign err_valid_o = err_valid_q;
  assign err_code_o  = err_code_q;
  assign err_slot_o  = err_slot_q;
  assign free_cnt_o  = free_cnt_q;

endmodule

// File: tb/tb_prof_slot_sched.sv
// Directed scoreboard bench for prof_slot_sched (8 slots, watchdog limit 16 when enabled).
module tb_prof_slot_sched;

  logic       clki = 1'b0;
  logic       rstni = 1'b0;
  logic       alloc_req_i, alloc_type_i, alloc_gnt_o;
  logic [7:0] alloc_task_i;
  logic [2:0] alloc_slot_o;
  logic       sub_done_i, sub_ok_i;
  logic [2:0] sub_slot_i, sub_id_i;
  logic       job_valid_o, job_ready_i, job_type_o;
  logic [2:0] job_slot_o;
  logic [7:0] job_task_o;
  logic [9:0] job_len_o;
  logic       res_valid_i;
  logic [2:0] res_slot_i;
  logic [3:0] free_cnt_o;
  logic       err_valid_o;
  logic [1:0] err_code_o;
  logic [2:0] err_slot_o;

  always #5 clki = ~clki;

  prof_slot_sched #(.NSLOT(8), .TMO_CYC(16)) dut (
    .clki(clki), .rstni(rstni),
    .alloc_req_i(alloc_req_i), .alloc_task_i(alloc_task_i), .alloc_type_i(alloc_type_i),
    .alloc_gnt_o(alloc_gnt_o), .alloc_slot_o(alloc_slot_o),
    .sub_done_i(sub_done_i), .sub_slot_i(sub_slot_i), .sub_id_i(sub_id_i), .sub_ok_i(sub_ok_i),
    .job_valid_o(job_valid_o), .job_ready_i(job_ready_i), .job_slot_o(job_slot_o),
    .job_task_o(job_task_o), .job_type_o(job_type_o), .job_len_o(job_len_o),
    .res_valid_i(res_valid_i), .res_slot_i(res_slot_i), .free_cnt_o(free_cnt_o),
    .err_valid_o(err_valid_o), .err_code_o(err_code_o), .err_slot_o(err_slot_o)
  );

  typedef struct {
    logic [2:0] slot;
    logic [7:0] tsk;
    logic       ty;
  } job_t;

  job_t jq[$];
  int   n_chk = 0;
  int   n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_len(input logic ty);
    return ty ? 32'd636 : 32'd364;
  endfunction

  task automatic clear_in();
    alloc_req_i = 1'b0; alloc_task_i = '0; alloc_type_i = 1'b0;
    sub_done_i = 1'b0; sub_slot_i = '0; sub_id_i = '0; sub_ok_i = 1'b0;
    job_ready_i = 1'b0; res_valid_i = 1'b0; res_slot_i = '0;
  endtask

  task automatic do_reset();
    @(negedge clki);
    rstni = 1'b0;
    clear_in();
    #1;
    chk("rst_job_valid", 32'(job_valid_o), 0);
    chk("rst_job_slot", 32'(job_slot_o), 0);
    chk("rst_job_task", 32'(job_task_o), 0);
    chk("rst_job_type", 32'(job_type_o), 0);
    chk("rst_job_len", 32'(job_len_o), 0);
    chk("rst_err_valid", 32'(err_valid_o), 0);
    chk("rst_err_code", 32'(err_code_o), 0);
    chk("rst_err_slot", 32'(err_slot_o), 0);
    chk("rst_alloc_gnt", 32'(alloc_gnt_o), 0);
    chk("rst_alloc_slot", 32'(alloc_slot_o), 0);
    chk("rst_free_cnt", 32'(free_cnt_o), 8);
    jq.delete();
    @(negedge clki);
    rstni = 1'b1;
  endtask

  task automatic idle();
    @(negedge clki);
    clear_in();
    #1;
  endtask

  task automatic do_alloc(input logic [7:0] t, input logic ty, input logic [2:0] exp_slot);
    @(negedge clki);
    clear_in();
    alloc_req_i = 1'b1; alloc_task_i = t; alloc_type_i = ty;
    #1;
    chk("alloc_gnt", 32'(alloc_gnt_o), 1);
    chk("alloc_slot", 32'(alloc_slot_o), 32'(exp_slot));
  endtask

  task automatic do_sub(input logic [2:0] s, input logic [2:0] id, input logic ok);
    @(negedge clki);
    clear_in();
    sub_done_i = 1'b1; sub_slot_i = s; sub_id_i = id; sub_ok_i = ok;
  endtask

  task automatic do_res(input logic [2:0] s);
    @(negedge clki);
    clear_in();
    res_valid_i = 1'b1; res_slot_i = s;
  endtask

  task automatic complete(input logic [2:0] s, input logic ty, input logic [7:0] t);
    for (int id = 0; id < (ty ? 5 : 3); id++) do_sub(s, 3'(id), 1'b1);
    jq.push_back('{slot: s, tsk: t, ty: ty});
  endtask

  task automatic exp_err(input logic [1:0] code, input logic [2:0] s, input logic [3:0] fc);
    idle();
    chk("err_valid", 32'(err_valid_o), 1);
    chk("err_code", 32'(err_code_o), 32'(code));
    chk("err_slot", 32'(err_slot_o), 32'(s));
    chk("err_free_cnt", 32'(free_cnt_o), 32'(fc));
  endtask

  task automatic wait_job();
    int n;
    n = 0;
    idle();
    while (job_valid_o !== 1'b1 && n < 30) begin
      @(negedge clki);
      #1;
      n++;
    end
    chk("job_valid", 32'(job_valid_o), 1);
  endtask

  task automatic check_job(input job_t e);
    chk("job_slot", 32'(job_slot_o), 32'(e.slot));
    chk("job_task", 32'(job_task_o), 32'(e.tsk));
    chk("job_type", 32'(job_type_o), 32'(e.ty));
    chk("job_len", 32'(job_len_o), exp_len(e.ty));
  endtask

  task automatic take_job();
    job_t e;
    wait_job();
    if (jq.size() > 0) begin
      e = jq.pop_front();
      check_job(e);
    end
    job_ready_i = 1'b1;
    idle();
    chk("job_drop", 32'(job_valid_o), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    job_t e;
    int   err_seen;
    clear_in();

    // single type-1 frame
    do_reset();
    do_alloc(8'h2a, 1'b1, 3'd0);
    do_sub(3'd0, 3'd0, 1'b1);
    #1 chk("free_after_alloc", 32'(free_cnt_o), 7);
    for (int id = 1; id < 5; id++) do_sub(3'd0, 3'(id), 1'b1);
    jq.push_back('{slot: 3'd0, tsk: 8'h2a, ty: 1'b1});
    take_job();
    do_res(3'd0);
    idle();
    chk("free_after_res", 32'(free_cnt_o), 8);

    // round-robin issue order with wrap
    do_reset();
    do_alloc(8'h10, 1'b0, 3'd0);
    do_alloc(8'h11, 1'b0, 3'd1);
    do_alloc(8'h12, 1'b0, 3'd2);
    do_alloc(8'h13, 1'b0, 3'd3);
    complete(3'd0, 1'b0, 8'h10);
    take_job();
    complete(3'd1, 1'b0, 8'h11);
    complete(3'd2, 1'b0, 8'h12);
    do_res(3'd0);
    take_job();
    complete(3'd3, 1'b0, 8'h13);
    do_res(3'd1);
    take_job();
    do_alloc(8'h14, 1'b0, 3'd0);
    complete(3'd0, 1'b0, 8'h14);
    do_res(3'd2);
    take_job();
    do_res(3'd3);
    take_job();
    do_res(3'd0);
    idle();
    chk("rr_free_cnt", 32'(free_cnt_o), 8);
    chk("rr_no_err", 32'(err_valid_o), 0);

    // full buffer, grant only after the freeing edge
    do_reset();
    for (int i = 0; i < 8; i++) do_alloc(8'(8'h20 + i), 1'b1, 3'(i));
    idle();
    chk("full_free_cnt", 32'(free_cnt_o), 0);
    alloc_req_i = 1'b1;
    #1 chk("ninth_gnt", 32'(alloc_gnt_o), 0);
    complete(3'd5, 1'b1, 8'h25);
    take_job();
    @(negedge clki);
    clear_in();
    res_valid_i = 1'b1; res_slot_i = 3'd5; alloc_req_i = 1'b1;
    #1 chk("gnt_same_cycle_as_free", 32'(alloc_gnt_o), 0);
    do_alloc(8'h30, 1'b0, 3'd5);

    // error codes and priority
    do_reset();
    do_alloc(8'h40, 1'b0, 3'd0);
    do_sub(3'd0, 3'd3, 1'b1);
    exp_err(2'd1, 3'd0, 4'd8);
    idle();
    chk("err_one_cycle", 32'(err_valid_o), 0);
    do_alloc(8'h41, 1'b1, 3'd0);
    do_sub(3'd0, 3'd2, 1'b1);
    do_sub(3'd0, 3'd1, 1'b0);
    res_valid_i = 1'b1; res_slot_i = 3'd6;
    exp_err(2'd0, 3'd0, 4'd8);
    do_sub(3'd3, 3'd0, 1'b1);
    exp_err(2'd2, 3'd3, 4'd8);
    do_res(3'd2);
    exp_err(2'd2, 3'd2, 4'd8);

    // fill watchdog
    do_reset();
    do_alloc(8'h50, 1'b0, 3'd0);
`ifdef PROF_SCHED_TMO_EN
    begin
      int n;
      n = 0;
      idle();
      while (err_valid_o !== 1'b1 && n < 40) begin
        @(negedge clki);
        #1;
        n++;
      end
      chk("tmo_err_valid", 32'(err_valid_o), 1);
      chk("tmo_err_code", 32'(err_code_o), 3);
      chk("tmo_err_slot", 32'(err_slot_o), 0);
      chk("tmo_free_cnt", 32'(free_cnt_o), 8);
    end
`else
    err_seen = 0;
    repeat (40) begin
      idle();
      if (err_valid_o !== 1'b0) err_seen++;
    end
    chk("no_tmo_err", 32'(err_seen), 0);
    chk("no_tmo_free_cnt", 32'(free_cnt_o), 7);
`endif

    // stable offer under backpressure, then reset mid-offer
    do_reset();
    do_alloc(8'h60, 1'b0, 3'd0);
    complete(3'd0, 1'b0, 8'h60);
    wait_job();
    if (jq.size() > 0) begin
      e = jq.pop_front();
      repeat (3) begin
        check_job(e);
        chk("hold_valid", 32'(job_valid_o), 1);
        idle();
      end
    end
    do_reset();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
